div_iter_param: RTL
===================

Name: div_iter_param

Overview:
- Parametrised successor to the EX-stage iterative radix-2 restoring divider used by DIV/DIVU.
- Operand width is configurable.
- Optional early-out skips leading-zero bits of the dividend magnitude, so short operands finish in fewer cycles.
- Operands and signs are latched at start, and divide-by-zero is flagged explicitly.
- Drives the HI/LO write path: remainder goes to HI, quotient goes to LO.

Parameters:
- WIDTH, 32, operand width in bits (>=4).
- EARLY_OUT, 1, when 1 the leading zeros of |dividend| are skipped; when 0 every divide takes the full WIDTH iterations.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-low reset.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at start.
- opdata1_i  in  WIDTH  dividend; sampled at start.
- opdata2_i  in  WIDTH  divisor; sampled at start.
- start_i  in  1  request; must be held high until ready_o is seen.
- annul_i  in  1  abort (flush or exception).
- result_o  out  2*WIDTH  {remainder, quotient}.
- ready_o  out  1  result valid.
- div_zero_o  out  1  divisor was zero; valid while ready_o is high.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE, and result_o, ready_o, div_zero_o and busy_o all go to 0. Reset wins over every other input at any state, including mid-division.
- States: IDLE, DIVZERO, ON, END.
- IDLE, on start_i=1 and annul_i=0:
  - Latch sign1=signed_div_i&op1[MSB] and sign2=signed_div_i&op2[MSB].
  - Latch |op1| and |op2| (two's-complement negate when the sign bit is latched as 1).
  - If op2==0, go to DIVZERO.
  - Otherwise compute lz = number of leading zeros of |op1| when EARLY_OUT=1, else lz=0.
  - Load the (2*WIDTH+1)-bit shift register with |op1|<<lz at bits [WIDTH:1] and zeros elsewhere; set cnt=lz; go to ON.
  - If |op1|==0 with EARLY_OUT=1, then lz=WIDTH and ON performs zero iterations.
- IDLE without a start: outputs are held at 0.
- ON, iteration cycle (annul_i=0, cnt!=WIDTH):
  - diff = {0, sr[2W-1:W]} - {0, divisor}, computed (WIDTH+1) bits wide.
  - If diff is negative, sr <= sr<<1.
  - Otherwise sr <= {diff[W-1:0], sr[W-1:0], 1}.
  - cnt <= cnt+1.
- ON, fixup cycle (cnt==WIDTH):
  - Quotient sr[W-1:0] is negated if sign1^sign2.
  - Remainder sr[2W:W+1] is negated if sign1 (remainder takes the dividend's sign).
  - Go to END.
- ON with annul_i=1: go to IDLE immediately. ready_o stays 0 and the result is discarded.
- DIVZERO:
  - If annul_i=1, go to IDLE.
  - Otherwise clear sr, set the dz flag, go to END.
- END:
  - Register result_o={rem,quo}, ready_o=1, div_zero_o=dz.
  - Hold these while start_i=1. annul_i is ignored in END.
  - When start_i=0: go to IDLE and clear result_o, ready_o and div_zero_o to 0 in the same edge.
- Latency:
  - Edge numbering: edge 1 is the accept edge (IDLE->ON).
  - ready_o rises after edge N+3, where N = WIDTH-lz.
  - Divide-by-zero: ready_o rises after edge 3.
  - Worst case (WIDTH=32): edge 35.
- Overflow: signed most-negative / -1 gives quotient = most-negative (wraps) and remainder 0. No flag is raised.
- Arithmetic:
  - All magnitude negation is modulo 2^WIDTH.
  - cnt width is clog2(WIDTH)+1.
  - The leading-zero count is a combinational priority encode on the latched-path magnitude.
- Operand inputs may change after the accept edge without effect, because signs and magnitudes are latched.

Test Plan:
- Unsigned 100/7, EARLY_OUT=1, WIDTH=32: lz=25 so N=7. Require ready_o after edge 10 and result_o={0x00000002, 0x0000000E}. Repeat with EARLY_OUT=0: same result, ready after edge 35.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002): require quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/-2: require quotient 0xFFFFFFFD, remainder 0x00000001.
- 5/0, both signed and unsigned: require ready_o and div_zero_o high after edge 3, result_o=0, busy_o high from edge 1 through END. Drop start_i: require all outputs 0 on the next edge.
- Signed 0x80000000 / 0xFFFFFFFF: require quotient 0x80000000, remainder 0, div_zero_o=0. Unsigned 0xFFFFFFFF / 1: require quotient 0xFFFFFFFF, remainder 0, ready after edge 35.
- Start 0xFFFFFFFF/3, then assert annul_i for one cycle at iteration 10: require IDLE on the next edge and ready_o never high. A fresh start of 9/3 then yields {0, 3}.
- Assert rst=0 mid-ON and again in END: require all outputs 0 on the following edge. Hold start_i high in END for 5 cycles: require result_o and ready_o to stay stable.

Source files
------------

// File: rtl/div_iter_param_if.sv
// Handshake and operand bundle between the EX stage and the iterative divider.
interface div_iter_param_if #(
  parameter int WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               div_zero_o;
  logic               busy_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, div_zero_o, busy_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, div_zero_o, busy_o
  );
endinterface

// File: rtl/div_iter_param.sv
// Iterative radix-2 restoring divider for DIV/DIVU with optional leading-zero early-out.
// Result is {remainder, quotient} for the HI/LO write path.
module div_iter_param #(
  parameter int WIDTH     = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  div_iter_param_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int SW = 2 * WIDTH + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

  state_t             state_reg, state_next;
  logic [SW-1:0]      sr_reg, sr_next;
  logic [WIDTH-1:0]   divisor_reg, divisor_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic               sign1_reg, sign1_next;
  logic               sign2_reg, sign2_next;
  logic               dz_reg, dz_next;
  logic [2*WIDTH-1:0] result_reg, result_next;
  logic               ready_reg, ready_next;
  logic               div_zero_reg, div_zero_next;

  logic               in_sign1, in_sign2;
  logic [WIDTH-1:0]   abs1, abs2, abs1_shl;
  logic [CW-1:0]      lz;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   quo, rem, quo_fix, rem_fix;

  assign in_sign1 = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
  assign in_sign2 = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
  assign abs1     = in_sign1 ? -bus.opdata1_i : bus.opdata1_i;
  assign abs2     = in_sign2 ? -bus.opdata2_i : bus.opdata2_i;

  // Highest set bit wins; an all-zero magnitude yields WIDTH so ON goes straight to fixup.
  always_comb begin
    lz = CNT_MAX;
    for (int i = 0; i < WIDTH; i++) begin
      if (abs1[i]) lz = CW'(WIDTH - 1 - i);
    end
    if (!EARLY_OUT) lz = '0;
  end

  assign abs1_shl = abs1 << lz;
  assign diff     = {1'b0, sr_reg[2*WIDTH-1:WIDTH]} - {1'b0, divisor_reg};
  assign quo      = sr_reg[WIDTH-1:0];
  assign rem      = sr_reg[2*WIDTH:WIDTH+1];
  assign quo_fix  = (sign1_reg ^ sign2_reg) ? -quo : quo;
  assign rem_fix  = sign1_reg ? -rem : rem;

  always_comb begin
    state_next    = state_reg;
    sr_next       = sr_reg;
    divisor_next  = divisor_reg;
    cnt_next      = cnt_reg;
    sign1_next    = sign1_reg;
    sign2_next    = sign2_reg;
    dz_next       = dz_reg;
    result_next   = result_reg;
    ready_next    = ready_reg;
    div_zero_next = div_zero_reg;

    unique case (state_reg)
      IDLE: begin
        result_next   = '0;
        ready_next    = 1'b0;
        div_zero_next = 1'b0;
        if (bus.start_i && !bus.annul_i) begin
          sign1_next   = in_sign1;
          sign2_next   = in_sign2;
          divisor_next = abs2;
          dz_next      = 1'b0;
          if (abs2 == '0) begin
            state_next = DIVZERO;
          end else begin
            sr_next    = {{WIDTH{1'b0}}, abs1_shl, 1'b0};
            cnt_next   = lz;
            state_next = ON;
          end
        end
      end
      ON: begin
        if (bus.annul_i) begin
          state_next = IDLE;
        end else if (cnt_reg != CNT_MAX) begin
          sr_next  = diff[WIDTH] ? {sr_reg[SW-2:0], 1'b0}
                                 : {diff[WIDTH-1:0], sr_reg[WIDTH-1:0], 1'b1};
          cnt_next = cnt_reg + 1'b1;
        end else begin
          // Repack signed results into the same slots END reads from.
          sr_next    = {rem_fix, 1'b0, quo_fix};
          state_next = END;
        end
      end
      DIVZERO: begin
        if (bus.annul_i) begin
          state_next = IDLE;
        end else begin
          sr_next    = '0;
          dz_next    = 1'b1;
          state_next = END;
        end
      end
      END: begin
        if (bus.start_i) begin
          result_next   = {sr_reg[2*WIDTH:WIDTH+1], sr_reg[WIDTH-1:0]};
          ready_next    = 1'b1;
          div_zero_next = dz_reg;
        end else begin
          result_next   = '0;
          ready_next    = 1'b0;
          div_zero_next = 1'b0;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      sr_reg       <= '0;
      divisor_reg  <= '0;
      cnt_reg      <= '0;
      sign1_reg    <= 1'b0;
      sign2_reg    <= 1'b0;
      dz_reg       <= 1'b0;
      result_reg   <= '0;
      ready_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sr_reg       <= sr_next;
      divisor_reg  <= divisor_next;
      cnt_reg      <= cnt_next;
      sign1_reg    <= sign1_next;
      sign2_reg    <= sign2_next;
      dz_reg       <= dz_next;
      result_reg   <= result_next;
      ready_reg    <= ready_next;
      div_zero_reg <= div_zero_next;
    end
  end

  assign bus.result_o   = result_reg;
  assign bus.ready_o    = ready_reg;
  assign bus.div_zero_o = div_zero_reg;
  assign bus.busy_o     = (state_reg != IDLE);
endmodule
